// File: rtl/fpu_addsub.sv
// Multi-cycle binary32 add/subtract unit. Operands come from the f-register file,
// and the result goes back to it as a one-cycle write-back pulse. Denormals are flushed to zero.
module fpu_addsub #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 5
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [DEPTH-1:0] rd_tag,
    output logic             busy,
    output logic             wb_we,
    output logic [DEPTH-1:0] wb_wa,
    output logic [WIDTH-1:0] wb_wd
);

    localparam int unsigned EW = 8;
    localparam int unsigned FW = 23;
    localparam int unsigned MW = FW + 1;
    localparam int unsigned AW = MW + 3;
    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    typedef enum logic [2:0] {IDLE, UNPACK, ALIGN, ADD, NORM} state_t;

    state_t          state;
    logic [31:0]     a_r, b_r;
    logic [DEPTH-1:0] tag_r;
    logic            spec_r, sgn_r, eff_sub_r;
    logic [31:0]     spec_val_r;
    logic [EW-1:0]   exp_r, diff_r;
    logic [MW-1:0]   m_big_r, m_small_r;
    logic [AW-1:0]   al_big_r, al_small_r;
    logic [AW:0]     sum_r;

    assign in_ready = rstn && (state == IDLE);
    assign busy     = (state != IDLE);

    // Unpack and classify; denormals count as zero
    logic          sa, sb, za, zb, ia, ib, na, nb, a_ge;
    logic [EW-1:0] ea, eb;
    logic [FW-1:0] fa, fb;
    logic          spec_c;
    logic [31:0]   spec_val_c;

    assign {sa, ea, fa} = a_r;
    assign {sb, eb, fb} = b_r;
    assign za   = (ea == '0);
    assign zb   = (eb == '0);
    assign ia   = (ea == '1) && (fa == '0);
    assign ib   = (eb == '1) && (fb == '0);
    assign na   = (ea == '1) && (fa != '0);
    assign nb   = (eb == '1) && (fb != '0);
    assign a_ge = (a_r[30:0] >= b_r[30:0]);

    always_comb begin
        spec_c     = 1'b1;
        spec_val_c = '0;
        if (na || nb)     spec_val_c = QNAN;
        else if (ia && ib) spec_val_c = (sa != sb) ? QNAN : {sa, 8'hFF, 23'h0};
        else if (ia)      spec_val_c = {sa, 8'hFF, 23'h0};
        else if (ib)      spec_val_c = {sb, 8'hFF, 23'h0};
        else if (za && zb) spec_val_c = {sa & sb, 31'h0};
        else if (za)      spec_val_c = b_r;
        else if (zb)      spec_val_c = a_r;
        else              spec_c     = 1'b0;
    end

    // Alignment: smaller significand shifted into a 27-bit field with G/R/sticky
    logic [50:0]   sh;
    logic [AW-1:0] al_small_c;

    always_comb begin
        sh = {m_small_r, 27'b0} >> diff_r;
        if (diff_r >= 8'd27) al_small_c = AW'(1);
        else                 al_small_c = {sh[50:25], sh[24] | (|sh[23:0])};
    end

    // Normalise, round to nearest even and pack
    logic [4:0]        lz;
    logic [AW-1:0]     nm;
    logic signed [9:0] ne, ne2;
    logic              up;
    logic [MW:0]       rm;
    logic [FW-1:0]     frac;
    logic [31:0]       res_c;

    always_comb begin
        lz = 5'd27;
        for (int i = 0; i < 27; i++) begin
            if (sum_r[i]) lz = 5'(26 - i);
        end
        if (sum_r[AW]) begin
            nm = {sum_r[AW:2], sum_r[1] | sum_r[0]};
            ne = 10'(exp_r) + 10'sd1;
        end else begin
            nm = sum_r[AW-1:0] << lz;
            ne = 10'(exp_r) - 10'(lz);
        end
        up   = nm[2] & (nm[1] | nm[0] | nm[3]);
        rm   = {1'b0, nm[AW-1:3]} + (MW+1)'(up);
        ne2  = rm[MW] ? ne + 10'sd1 : ne;
        frac = rm[MW] ? rm[MW-1:1] : rm[FW-1:0];
        if (spec_r)               res_c = spec_val_r;
        else if (sum_r == '0)     res_c = '0;
        else if (ne <= 10'sd0)    res_c = {sgn_r, 31'h0};
        else if (ne2 >= 10'sd255) res_c = {sgn_r, 8'hFF, 23'h0};
        else                      res_c = {sgn_r, ne2[7:0], frac};
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= IDLE;
            a_r        <= '0;
            b_r        <= '0;
            tag_r      <= '0;
            spec_r     <= 1'b0;
            spec_val_r <= '0;
            sgn_r      <= 1'b0;
            eff_sub_r  <= 1'b0;
            exp_r      <= '0;
            diff_r     <= '0;
            m_big_r    <= '0;
            m_small_r  <= '0;
            al_big_r   <= '0;
            al_small_r <= '0;
            sum_r      <= '0;
            wb_we      <= 1'b0;
            wb_wa      <= '0;
            wb_wd      <= '0;
        end else begin
            wb_we <= 1'b0;
            case (state)
                IDLE: if (in_valid) begin
                    a_r   <= a;
                    b_r   <= {b[31] ^ op, b[30:0]};
                    tag_r <= rd_tag;
                    state <= UNPACK;
                end
                UNPACK: begin
                    spec_r     <= spec_c;
                    spec_val_r <= spec_val_c;
                    sgn_r      <= a_ge ? sa : sb;
                    eff_sub_r  <= sa ^ sb;
                    exp_r      <= a_ge ? ea : eb;
                    diff_r     <= a_ge ? ea - eb : eb - ea;
                    m_big_r    <= a_ge ? {1'b1, fa} : {1'b1, fb};
                    m_small_r  <= a_ge ? {1'b1, fb} : {1'b1, fa};
                    state      <= ALIGN;
                end
                ALIGN: begin
                    al_big_r   <= {m_big_r, 3'b000};
                    al_small_r <= al_small_c;
                    state      <= ADD;
                end
                ADD: begin
                    sum_r <= eff_sub_r ? {1'b0, al_big_r} - {1'b0, al_small_r}
                                       : {1'b0, al_big_r} + {1'b0, al_small_r};
                    state <= NORM;
                end
                NORM: begin
                    wb_we <= 1'b1;
                    wb_wa <= tag_r;
                    wb_wd <= res_c;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_addsub.sv
// Directed-vector bench for fpu_addsub: latency, rounding, specials, back-to-back issue
// and reset abort.
module tb_fpu_addsub;

    logic        clk = 1'b0;
    logic        rstn;
    logic        in_valid;
    logic        in_ready;
    logic        op;
    logic [31:0] a, b;
    logic [4:0]  rd_tag;
    logic        busy;
    logic        wb_we;
    logic [4:0]  wb_wa;
    logic [31:0] wb_wd;

    int n_vec = 0;
    int n_err = 0;

    fpu_addsub #(.WIDTH(32), .DEPTH(5)) dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .a(a), .b(b), .rd_tag(rd_tag), .busy(busy),
        .wb_we(wb_we), .wb_wa(wb_wa), .wb_wd(wb_wd)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic run_vec(input logic [31:0] va, input logic [31:0] vb, input logic vop,
                           input logic [4:0] vt, input logic [31:0] vexp);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("ready_before_issue", 32'(in_ready), 32'd1);
        a = va; b = vb; op = vop; rd_tag = vt; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = $urandom; b = $urandom; op = ~vop; rd_tag = 5'(~vt);
        for (int i = 0; i < 4; i++) begin
            check("busy_ready_low", 32'(in_ready), 32'd0);
            check("we_low_in_flight", 32'(wb_we), 32'd0);
            @(posedge clk); #1;
        end
        check("we_pulse", 32'(wb_we), 32'd1);
        check("wa", 32'(wb_wa), 32'(vt));
        check("wd", wb_wd, vexp);
        check("ready_at_wb", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        check("we_after_pulse", 32'(wb_we), 32'd0);
        check("wd_hold", wb_wd, vexp);
    endtask

    localparam int NV = 12;
    logic [31:0] va_t [NV] = '{32'h3F800000, 32'h40400000, 32'h3F800000, 32'h80000000,
                               32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h7F800000,
                               32'h7FC00001, 32'h7F7FFFFF, 32'h00800000, 32'h00000000};
    logic [31:0] vb_t [NV] = '{32'h40000000, 32'h3F800000, 32'h3F800000, 32'h80000000,
                               32'h33800000, 32'h33C00000, 32'h00400000, 32'hFF800000,
                               32'h3F800000, 32'h7F7FFFFF, 32'h00800001, 32'hC0A00000};
    logic        vo_t [NV] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                               1'b0, 1'b0, 1'b1, 1'b0};
    logic [31:0] ve_t [NV] = '{32'h40400000, 32'h40000000, 32'h00000000, 32'h80000000,
                               32'h3F800000, 32'h3F800001, 32'h3F800000, 32'h7FC00000,
                               32'h7FC00000, 32'h7F800000, 32'h80000000, 32'hC0A00000};

    initial begin
        rstn = 1'b0; in_valid = 1'b0; op = 1'b0; a = '0; b = '0; rd_tag = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_we", 32'(wb_we), 32'd0);
        check("rst_wa", 32'(wb_wa), 32'd0);
        check("rst_wd", wb_wd, 32'd0);
        check("rst_ready_forced_low", 32'(in_ready), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        #1;
        check("ready_after_rst", 32'(in_ready), 32'd1);

        for (int i = 0; i < NV; i++) begin
            run_vec(va_t[i], vb_t[i], vo_t[i], (i == 0) ? 5'd3 : 5'(i + 8), ve_t[i]);
        end

        // Back-to-back: second issue accepted in the cycle of the first write-back
        @(negedge clk);
        a = 32'h3F800000; b = 32'h40000000; op = 1'b0; rd_tag = 5'd3; in_valid = 1'b1;
        @(posedge clk); #1;
        a = 32'h40400000; b = 32'h3F800000; op = 1'b1; rd_tag = 5'd7;
        for (int i = 0; i < 4; i++) begin
            check("b2b_busy1", 32'(in_ready), 32'd0);
            @(posedge clk); #1;
        end
        check("b2b_we1", 32'(wb_we), 32'd1);
        check("b2b_wa1", 32'(wb_wa), 32'd3);
        check("b2b_wd1", wb_wd, 32'h40400000);
        check("b2b_ready1", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("b2b_accepted", 32'(busy), 32'd1);
        for (int i = 0; i < 4; i++) begin
            check("b2b_we_gap", 32'(wb_we), 32'd0);
            if (i < 3) begin
                @(posedge clk); #1;
            end
        end
        @(posedge clk); #1;
        check("b2b_we2", 32'(wb_we), 32'd1);
        check("b2b_wa2", 32'(wb_wa), 32'd7);
        check("b2b_wd2", wb_wd, 32'h40000000);

        // Reset in the middle of an operation aborts it
        @(negedge clk);
        a = 32'h3F800000; b = 32'h3F800000; op = 1'b0; rd_tag = 5'd9; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        rstn = 1'b0;
        @(posedge clk); #1;
        check("abort_we", 32'(wb_we), 32'd0);
        check("abort_wa", 32'(wb_wa), 32'd0);
        check("abort_wd", wb_wd, 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_ready_low", 32'(in_ready), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        #1;
        check("abort_ready_high", 32'(in_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("abort_no_we", 32'(wb_we), 32'd0);
        end
        run_vec(32'h3F800000, 32'h3F800000, 1'b0, 5'd21, 32'h40000000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
